// File: rtl/apb_slave_array_if.sv
// APB bus bundle between the bridge's APB master and the slave register array.
// Also carries the slave's saturating error counter out to the observer.
interface apb_slave_array_if #(
  parameter int NUM_SLAVES = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [NUM_SLAVES-1:0] Pselx;
  logic                  Penable;
  logic                  Pwrite;
  logic [ADDR_WIDTH-1:0] Paddr;
  logic [DATA_WIDTH-1:0] Pwdata;
  logic [DATA_WIDTH-1:0] Prdata;
  logic                  Pready;
  logic                  Pslverr;
  logic [7:0]            err_count;

  modport master (
    output Pselx, Penable, Pwrite, Paddr, Pwdata,
    input  Prdata, Pready, Pslverr, err_count
  );

  modport slave (
    input  Pselx, Penable, Pwrite, Paddr, Pwdata,
    output Prdata, Pready, Pslverr, err_count
  );
endinterface

// File: rtl/apb_slave_array.sv
// Clocked APB slave terminating the bus in NUM_SLAVES word-addressed register banks,
// with programmable wait states, error response and a saturating error counter.
module apb_slave_bank #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 32,
  parameter int IW         = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [IW-1:0]         idx_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)     mem_q <= '0;
    else if (we_i) mem_q[idx_i] <= wdata_i;
  end

  assign rdata_o = mem_q[idx_i];
endmodule

module apb_slave_array #(
  parameter int NUM_SLAVES  = 3,
  parameter int DEPTH       = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic             Hclk,
  input  logic             Hreset,
  apb_slave_array_if.slave bus
);
  localparam int          IW        = $clog2(DEPTH);
  localparam logic [0:0]  S_IDLE    = 1'b0;
  localparam logic [0:0]  S_ACCESS  = 1'b1;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  logic [0:0]             state_q, state_d;
  logic [NUM_SLAVES-1:0]  sel_q, sel_d;
  logic [ADDR_WIDTH-1:2]  addr_q, addr_d;
  logic                   write_q, write_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [3:0]             wait_q, wait_d;
  logic [7:0]             errc_q, errc_d;

  logic [IW-1:0]                          idx;
  logic                                   addr_err, sel_err, xfer_err, done;
  logic [NUM_SLAVES-1:0]                  bank_we;
  logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0]  bank_rdata;
  logic [DATA_WIDTH-1:0]                  rd_sel;
  logic                                   unused_addr_lsb;

  // Byte offset within the word carries no meaning for a word-addressed bank.
  assign unused_addr_lsb = ^bus.Paddr[1:0];

  assign idx      = addr_q[IW+1:2];
  assign addr_err = |addr_q[ADDR_WIDTH-1:IW+2];
  assign sel_err  = |(sel_q & (sel_q - 1'b1));
  assign xfer_err = addr_err | sel_err;

  // Completion also needs a live select so an abort can never raise Pready.
  assign done = (state_q == S_ACCESS) && (|bus.Pselx) && bus.Penable && (wait_q == '0);

  genvar g;
  generate
    for (g = 0; g < NUM_SLAVES; g++) begin : g_bank
      assign bank_we[g] = done & write_q & ~xfer_err & sel_q[g];
      apb_slave_bank #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .IW(IW)) u_bank (
        .clk_i   (Hclk),
        .rst_i   (Hreset),
        .we_i    (bank_we[g]),
        .idx_i   (idx),
        .wdata_i (wdata_q),
        .rdata_o (bank_rdata[g])
      );
    end
  endgenerate

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (sel_q[i]) rd_sel = rd_sel | bank_rdata[i];
  end

  assign bus.Pready    = done;
  assign bus.Pslverr   = done & xfer_err;
  assign bus.Prdata    = (done & ~write_q & ~xfer_err) ? rd_sel : '0;
  assign bus.err_count = errc_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    wait_d  = wait_q;
    errc_d  = errc_q;
    case (state_q)
      S_IDLE: begin
        // Penable without a preceding setup is a protocol error and is ignored.
        if ((|bus.Pselx) && !bus.Penable) begin
          sel_d   = bus.Pselx;
          addr_d  = bus.Paddr[ADDR_WIDTH-1:2];
          write_d = bus.Pwrite;
          wdata_d = bus.Pwdata;
          wait_d  = WAIT_INIT;
          state_d = S_ACCESS;
        end
      end
      default: begin
        if (~|bus.Pselx) begin
          state_d = S_IDLE;
        end else if (bus.Penable) begin
          if (wait_q != '0) begin
            wait_d = wait_q - 4'd1;
          end else begin
            state_d = S_IDLE;
            if (xfer_err && errc_q != 8'hFF) errc_d = errc_q + 8'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      wait_q  <= '0;
      errc_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      wait_q  <= wait_d;
      errc_q  <= errc_d;
    end
  end
endmodule

// File: tb/tb_apb_slave_array.sv
// Randomised bench for apb_slave_array: two instances (0 and 3 wait states) checked
// every cycle against a transaction-level model, plus directed literal checks.
module tb_apb_slave_array;
  localparam int NS = 3, DEPTH = 16, DW = 32, AW = 32;

  logic Hclk = 1'b0;
  logic Hreset;
  always #5 Hclk = ~Hclk;

  logic [NS-1:0] psel;
  logic          pen, pwrite;
  logic [31:0]   paddr, pwdata;
  bit            which;

  apb_slave_array_if #(.NUM_SLAVES(NS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if0 ();
  apb_slave_array_if #(.NUM_SLAVES(NS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if3 ();

  assign if0.Pselx   = which ? '0 : psel;
  assign if0.Penable = which ? 1'b0 : pen;
  assign if0.Pwrite  = pwrite;
  assign if0.Paddr   = paddr;
  assign if0.Pwdata  = pwdata;
  assign if3.Pselx   = which ? psel : '0;
  assign if3.Penable = which ? pen : 1'b0;
  assign if3.Pwrite  = pwrite;
  assign if3.Paddr   = paddr;
  assign if3.Pwdata  = pwdata;

  apb_slave_array #(.NUM_SLAVES(NS), .DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                    .WAIT_STATES(0)) u_dut0 (.Hclk(Hclk), .Hreset(Hreset), .bus(if0.slave));
  apb_slave_array #(.NUM_SLAVES(NS), .DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                    .WAIT_STATES(3)) u_dut3 (.Hclk(Hclk), .Hreset(Hreset), .bus(if3.slave));

  wire        rdy = which ? if3.Pready  : if0.Pready;
  wire        err = which ? if3.Pslverr : if0.Pslverr;
  wire [31:0] rdd = which ? if3.Prdata  : if0.Prdata;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Transaction-level model: one pending transfer per instance and a count of
  // enabled access cycles seen; completion happens on the (WS+1)-th of them.
  logic [31:0] mem [2][NS][DEPTH];
  int          ec   [2];
  bit          pend [2];
  logic [2:0]  tsel [2];
  logic [31:0] taddr[2];
  logic [31:0] tdata[2];
  bit          twr  [2];
  int          nen  [2];

  always @(negedge Hclk) begin
    logic [2:0]  sk;
    logic        ek, x_rdy, x_err, a_rdy, a_err, terr;
    logic [31:0] x_rd, a_rd, a_ec;
    int          ws, b, wi;
    for (int k = 0; k < 2; k++) begin
      sk = (int'(which) == k) ? psel : 3'b0;
      ek = (int'(which) == k) ? pen : 1'b0;
      ws = (k == 0) ? 0 : 3;
      a_rdy = (k == 0) ? if0.Pready : if3.Pready;
      a_err = (k == 0) ? if0.Pslverr : if3.Pslverr;
      a_rd  = (k == 0) ? if0.Prdata : if3.Prdata;
      a_ec  = (k == 0) ? 32'(if0.err_count) : 32'(if3.err_count);
      b = 0;
      for (int i = NS - 1; i >= 0; i--) if (tsel[k][i]) b = i;
      wi   = int'((taddr[k] >> 2) % DEPTH);
      terr = ($countones(tsel[k]) > 1) || ((taddr[k] >> 6) != 0);
      x_rdy = pend[k] && (sk != 0) && ek && (nen[k] == ws);
      x_err = x_rdy && terr;
      x_rd  = (x_rdy && !twr[k] && !terr) ? mem[k][b][wi] : 32'h0;
      if (!Hreset) begin
        chk($sformatf("dut%0d Pready", k), 32'(a_rdy), 32'(x_rdy));
        chk($sformatf("dut%0d Pslverr", k), 32'(a_err), 32'(x_err));
        chk($sformatf("dut%0d Prdata", k), a_rd, x_rd);
        chk($sformatf("dut%0d err_count", k), a_ec, 32'(ec[k]));
      end
      if (Hreset) begin
        pend[k] <= 1'b0;
        ec[k]   <= 0;
        for (int s = 0; s < NS; s++)
          for (int d = 0; d < DEPTH; d++) mem[k][s][d] <= 32'h0;
      end else if (!pend[k]) begin
        if (sk != 0 && !ek) begin
          pend[k] <= 1'b1; tsel[k] <= sk; taddr[k] <= paddr;
          tdata[k] <= pwdata; twr[k] <= pwrite; nen[k] <= 0;
        end
      end else if (sk == 0) begin
        pend[k] <= 1'b0;
      end else if (ek) begin
        if (x_rdy) begin
          pend[k] <= 1'b0;
          if (terr) ec[k] <= (ec[k] < 255) ? ec[k] + 1 : 255;
          else if (twr[k]) mem[k][b][wi] <= tdata[k];
        end else nen[k] <= nen[k] + 1;
      end
    end
  end

  // Directed transfer; enters and leaves 1 time unit after a rising edge.
  task automatic xfer(input bit k, input logic [2:0] sel, input logic [31:0] addr,
                      input logic wr, input logic [31:0] wd, input int drop_at,
                      output logic [31:0] rd, output logic er, output int cyc);
    bit got = 0;
    which = k; psel = sel; pen = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    rd = 32'h0; er = 1'b0; cyc = 0;
    @(posedge Hclk); #1;
    for (int c = 1; c <= 64; c++) begin
      pen = !(drop_at >= 0 && c > drop_at && c <= drop_at + 2);
      @(negedge Hclk);
      got = rdy; rd = rdd; er = err;
      @(posedge Hclk); #1;
      if (got) begin cyc = c; break; end
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL xfer_timeout: no Pready within 64 cycles, required completion");
    end
  endtask

  task automatic idle(input int n);
    psel = '0; pen = 1'b0;
    repeat (n) begin @(posedge Hclk); #1; end
  endtask

  task automatic rnd_xfer(input bit k);
    int r;
    bit got;
    which = k;
    r = $urandom_range(0, 9);
    if (r < 3) begin
      psel = (r == 0) ? 3'($urandom_range(1, 7)) : 3'b0;
      pen = 1'b1; pwrite = 1'($urandom);
      @(posedge Hclk); #1;
    end
    psel   = ($urandom_range(0, 9) < 8) ? 3'(3'b001 << $urandom_range(0, 2))
                                        : 3'($urandom_range(1, 7));
    pen    = 1'b0;
    pwrite = 1'($urandom);
    paddr  = ($urandom_range(0, 4) != 0) ? {26'b0, 6'($urandom)} : $urandom;
    pwdata = $urandom;
    @(posedge Hclk); #1;
    for (int c = 0; c < 64; c++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        psel = '0; pen = 1'b0;
        @(posedge Hclk); #1;
        return;
      end
      pen = (r > 4);
      paddr = $urandom; pwdata = $urandom; pwrite = 1'($urandom);
      @(negedge Hclk); got = rdy;
      @(posedge Hclk); #1;
      if (got) return;
    end
  endtask

  logic [31:0] rd;
  logic        er;
  int          cyc, seen;

  initial begin
    Hreset = 1'b1; psel = '0; pen = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; which = 0;
    repeat (2) @(posedge Hclk);
    #1 Hreset = 1'b0;
    @(negedge Hclk);
    chk("reset Prdata", if0.Prdata, 32'h0);
    chk("reset Pready", 32'(if0.Pready), 32'h0);
    chk("reset Pslverr", 32'(if0.Pslverr), 32'h0);
    chk("reset err_count", 32'(if0.err_count), 32'h0);
    @(posedge Hclk); #1;

    xfer(0, 3'b010, 32'h14, 1'b1, 32'h8765_4321, -1, rd, er, cyc);
    chk("ws0 write latency", 32'(cyc), 32'd1);
    chk("ws0 write slverr", 32'(er), 32'h0);
    xfer(0, 3'b010, 32'h14, 1'b0, 32'h0, -1, rd, er, cyc);
    chk("readback data", rd, 32'h8765_4321);
    chk("readback slverr", 32'(er), 32'h0);
    chk("model mem", mem[0][1][5], 32'h8765_4321);
    xfer(0, 3'b001, 32'h14, 1'b0, 32'h0, -1, rd, er, cyc);
    chk("bank isolation", rd, 32'h0);

    xfer(0, 3'b010, 32'h40, 1'b1, 32'hDEAD_BEEF, -1, rd, er, cyc);
    chk("addr err slverr", 32'(er), 32'h1);
    chk("addr err prdata", rd, 32'h0);
    chk("err_count 1", 32'(if0.err_count), 32'd1);
    xfer(0, 3'b010, 32'h0, 1'b0, 32'h0, -1, rd, er, cyc);
    chk("addr err bank unchanged", rd, 32'h0);
    xfer(0, 3'b011, 32'h8, 1'b1, 32'h1234, -1, rd, er, cyc);
    chk("sel err slverr", 32'(er), 32'h1);
    chk("err_count 2", 32'(if0.err_count), 32'd2);
    for (int i = 0; i < 300; i++)
      xfer(0, 3'b110, 32'h0, 1'($urandom), $urandom, -1, rd, er, cyc);
    chk("err_count saturate", 32'(if0.err_count), 32'd255);
    chk("model err_count", 32'(ec[0]), 32'd255);
    idle(2);

    xfer(1, 3'b100, 32'h20, 1'b1, 32'h5555_AAAA, -1, rd, er, cyc);
    chk("ws3 latency", 32'(cyc), 32'd4);
    xfer(1, 3'b100, 32'h20, 1'b0, 32'h0, 1, rd, er, cyc);
    chk("ws3 penable drop latency", 32'(cyc), 32'd6);
    chk("ws3 read data", rd, 32'h5555_AAAA);

    foreach (paddr[i]) ;
    seen = 0;
    for (int a = 0; a < 2; a++) begin
      which = 1; psel = 3'b100; pen = 1'b0; pwrite = 1'b1;
      paddr = (a == 0) ? 32'hAAAA_0008 : 32'h0000_0008; pwdata = 32'hABCD_EF01;
      @(posedge Hclk); #1;
      pen = 1'b1;
      @(negedge Hclk); seen += int'(rdy);
      @(posedge Hclk); #1;
      psel = '0; pen = 1'b0;
      repeat (3) begin @(negedge Hclk); seen += int'(rdy); @(posedge Hclk); #1; end
    end
    chk("abort no pready", 32'(seen), 32'h0);
    chk("abort no err_count", 32'(if3.err_count), 32'h0);
    xfer(1, 3'b100, 32'h8, 1'b0, 32'h0, -1, rd, er, cyc);
    chk("abort no write", rd, 32'h0);

    xfer(1, 3'b001, 32'h4, 1'b1, 32'hCAFE_F00D, -1, rd, er, cyc);
    xfer(1, 3'b001, 32'h4, 1'b0, 32'h0, -1, rd, er, cyc);
    chk("pre-reset readback", rd, 32'hCAFE_F00D);
    psel = 3'b001; pen = 1'b0; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'h1111_1111;
    @(posedge Hclk); #1;
    pen = 1'b1;
    @(posedge Hclk); #1;
    Hreset = 1'b1;
    @(posedge Hclk); #1;
    Hreset = 1'b0; psel = '0; pen = 1'b0;
    @(posedge Hclk); #1;
    xfer(1, 3'b001, 32'h4, 1'b0, 32'h0, -1, rd, er, cyc);
    chk("reset clears bank ws3", rd, 32'h0);
    xfer(0, 3'b010, 32'h14, 1'b0, 32'h0, -1, rd, er, cyc);
    chk("reset clears bank ws0", rd, 32'h0);
    chk("reset clears err_count", 32'(if0.err_count), 32'h0);

    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 150; i++) rnd_xfer(1'(k));
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end
endmodule
